// File: rtl/inv_stage3.sv
// inv_stage3: InvMixColumns round stage of the AES inverse cipher.
// Define INV_STAGE3_SERIAL_EN for the single-column serial datapath.
module inv_stage3 (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic [3:0]   num,
  output logic         ready,
  output logic         done,
  output logic [127:0] state_out,
  output logic [127:0] key_out,
  output logic [3:0]   num_out
);

  localparam logic [3:0] LAST = 4'ha;

  function automatic logic [7:0] xt(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] imc_col(
    input logic [31:0] c
  );
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [127:0] r_sout;
  logic [127:0] r_kout;
  logic [3:0]   r_nout;

  assign state_out = r_sout;
  assign key_out   = r_kout;
  assign num_out   = r_nout;

`ifdef INV_STAGE3_SERIAL_EN

  typedef enum logic [1:0] {
    IDLE,
    COL,
    OUT
  } fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_nxt;
  logic [1:0]   r_cnt;
  logic [127:0] r_work;
  logic [127:0] r_key;
  logic [3:0]   r_num;
  logic         w_acc;
  logic [31:0]  w_col_in;
  logic [31:0]  w_col_out;
  logic [127:0] w_work_nxt;

  assign ready = (r_fsm == IDLE);
  assign done  = (r_fsm == OUT);
  assign w_acc = en && ready;

  always_comb begin
    w_col_in = r_work[127:96];
    case (r_cnt)
      2'd0: w_col_in = r_work[127:96];
      2'd1: w_col_in = r_work[95:64];
      2'd2: w_col_in = r_work[63:32];
      2'd3: w_col_in = r_work[31:0];
      default: w_col_in = r_work[127:96];
    endcase
  end

  assign w_col_out = imc_col(w_col_in);

  always_comb begin
    w_work_nxt = r_work;
    case (r_cnt)
      2'd0: w_work_nxt[127:96] = w_col_out;
      2'd1: w_work_nxt[95:64]  = w_col_out;
      2'd2: w_work_nxt[63:32]  = w_col_out;
      2'd3: w_work_nxt[31:0]   = w_col_out;
      default: w_work_nxt = r_work;
    endcase
  end

  always_comb begin
    w_nxt = r_fsm;
    unique case (r_fsm)
      IDLE: begin
        if (w_acc) begin
          w_nxt = (num == LAST) ? OUT : COL;
        end
      end
      COL: begin
        if (r_cnt == 2'd3) begin
          w_nxt = OUT;
        end
      end
      OUT:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Result registers load on entry to OUT so they hold until the next done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fsm  <= IDLE;
      r_cnt  <= 2'd0;
      r_work <= '0;
      r_key  <= '0;
      r_num  <= '0;
      r_sout <= '0;
      r_kout <= '0;
      r_nout <= '0;
    end else begin
      r_fsm <= w_nxt;
      unique case (r_fsm)
        IDLE: begin
          if (w_acc) begin
            r_work <= state;
            r_key  <= key;
            r_num  <= num;
            r_cnt  <= 2'd0;
            if (num == LAST) begin
              r_sout <= state;
              r_kout <= key;
              r_nout <= num;
            end
          end
        end
        COL: begin
          r_work <= w_work_nxt;
          r_cnt  <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_sout <= w_work_nxt;
            r_kout <= r_key;
            r_nout <= r_num;
          end
        end
        OUT: begin
        end
        default: begin
        end
      endcase
    end
  end

`else

  logic         r_done;
  logic         w_acc;
  logic [127:0] w_imc;

  assign ready = 1'b1;
  assign done  = r_done;
  assign w_acc = en && ready;

  assign w_imc = {imc_col(state[127:96]),
                  imc_col(state[95:64]),
                  imc_col(state[63:32]),
                  imc_col(state[31:0])};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_done <= 1'b0;
      r_sout <= '0;
      r_kout <= '0;
      r_nout <= '0;
    end else begin
      r_done <= w_acc;
      if (w_acc) begin
        r_sout <= (num == LAST) ? state : w_imc;
        r_kout <= key;
        r_nout <= num;
      end
    end
  end

`endif

endmodule

// File: tb/tb_inv_stage3.sv
// tb_inv_stage3: scoreboard bench for inv_stage3.
// Works for both builds (INV_STAGE3_SERIAL_EN defined or not).
module tb_inv_stage3;

`ifdef INV_STAGE3_SERIAL_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [127:0] st;
    logic [127:0] ky;
    logic [3:0]   nm;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic [127:0] state;
  logic [127:0] key;
  logic [3:0]   num;
  logic         ready;
  logic         done;
  logic [127:0] state_out;
  logic [127:0] key_out;
  logic [3:0]   num_out;

  int   checks;
  int   errors;
  exp_t sb[$];

  inv_stage3 dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .state     (state),
    .key       (key),
    .num       (num),
    .ready     (ready),
    .done      (done),
    .state_out (state_out),
    .key_out   (key_out),
    .num_out   (num_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(
    input logic [127:0] s,
    input logic [3:0]   n
  );
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (n == 4'ha) return s;
    coef[0] = 8'h0e;
    coef[1] = 8'h0b;
    coef[2] = 8'h0d;
    coef[3] = 8'h09;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          acc = acc ^ gmul(s[127-8*(4*c+k) -: 8], coef[(k-row)&3]);
        end
        r[127-8*(4*c+row) -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic push(
    input logic [127:0] s,
    input logic [127:0] k,
    input logic [3:0]   n
  );
    exp_t e;
    e.st = model(s, n);
    e.ky = k;
    e.nm = n;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done num_out=%h", num_out);
      end else begin
        e = sb.pop_front();
        if (state_out !== e.st || key_out !== e.ky || num_out !== e.nm) begin
          errors++;
          $display("FAIL sb_result got %h/%h/%h want %h/%h/%h",
                   state_out, key_out, num_out, e.st, e.ky, e.nm);
        end
      end
    end
  end

  task automatic test_reset();
    rst   = 1'b0;
    en    = 1'b0;
    state = '0;
    key   = '0;
    num   = 4'h1;
    #3;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || state_out !== '0 ||
        key_out !== '0 || num_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_async got done=%b ready=%b so=%h ko=%h no=%h want 0/1/0/0/0",
               done, ready, state_out, key_out, num_out);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || state_out !== '0) begin
      errors++;
      $display("FAIL reset_held got done=%b ready=%b so=%h want 0/1/0",
               done, ready, state_out);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_one(
    input  logic [127:0] s,
    input  logic [3:0]   n,
    output int           lat
  );
    logic [127:0] k;
    k = rnd128();
    @(negedge clk);
    state = s;
    key   = k;
    num   = n;
    en    = 1'b1;
    push(s, k, n);
    @(posedge clk);
    #1 en = 1'b0;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
  endtask

  task automatic test_vector();
    int lat;
    run_one(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4'h3, lat);
    checks++;
    if (lat !== LAT || done !== 1'b1) begin
      errors++;
      $display("FAIL vec_latency got %0d want %0d", lat, LAT);
    end
    checks++;
    if (state_out !== 128'hdb135345_f20a225c_01010101_c6c6c6c6 || num_out !== 4'h3) begin
      errors++;
      $display("FAIL vec_state got %h want db135345f20a225c01010101c6c6c6c6", state_out);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || state_out !== 128'hdb135345_f20a225c_01010101_c6c6c6c6) begin
      errors++;
      $display("FAIL vec_hold got done=%b so=%h want 0/held", done, state_out);
    end
  endtask

  task automatic test_last_round();
    int lat;
    run_one(128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4'ha, lat);
    checks++;
    if (lat !== 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL last_latency got %0d want 1", lat);
    end
    checks++;
    if (state_out !== 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6 || num_out !== 4'ha) begin
      errors++;
      $display("FAIL last_state got %h/%h want 8e4da1bc9fdc589d01010101c6c6c6c6/a",
               state_out, num_out);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
`ifdef INV_STAGE3_SERIAL_EN
    int ndone;
    logic [127:0] s;
    logic [127:0] k;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) ndone++;
      checks++;
      if (ready !== ((i % 6) == 0)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b want %b", i, ready, (i % 6) == 0);
      end
      s     = rnd128();
      k     = rnd128();
      state = s;
      key   = k;
      num   = 4'(1 + (i % 9));
      en    = 1'b1;
      if ((i % 6) == 0) push(s, k, 4'(1 + (i % 9)));
    end
    @(negedge clk);
    en = 1'b0;
    if (done) ndone++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 2) begin
      errors++;
      $display("FAIL b2b_done_count got %0d want 2", ndone);
    end
`else
    logic [127:0] s;
    logic [127:0] k;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (done !== (i <= 4) || (i <= 4 && num_out !== 4'(i))) begin
          errors++;
          $display("FAIL b2b_cycle %0d got done=%b num=%h want %b/%h",
                   i, done, num_out, i <= 4, 4'(i));
        end
      end
      s     = rnd128();
      k     = rnd128();
      state = s;
      key   = k;
      num   = 4'(i + 1);
      en    = (i < 4);
      if (i < 4) push(s, k, 4'(i + 1));
    end
    en = 1'b0;
`endif
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ndone;
    @(negedge clk);
    state = rnd128();
    key   = rnd128();
    num   = 4'h2;
    en    = 1'b1;
`ifdef INV_STAGE3_SERIAL_EN
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
`else
    @(posedge clk);
    #1 en = 1'b0;
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || ready !== 1'b1 || state_out !== '0 ||
        key_out !== '0 || num_out !== 4'h0) begin
      errors++;
      $display("FAIL rstmid_clear got done=%b ready=%b so=%h ko=%h no=%h want 0/1/0/0/0",
               done, ready, state_out, key_out, num_out);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_ready got ready=%b done=%b want 1/0", ready, done);
    end
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++;
    if (ndone !== 0) begin
      errors++;
      $display("FAIL rstmid_no_done got %0d want 0", ndone);
    end
  endtask

  task automatic test_random();
    int acc;
    int cyc;
    logic [127:0] s;
    logic [127:0] k;
    logic [3:0]   n;
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      s     = rnd128();
      k     = rnd128();
      n     = 4'($urandom_range(1, 10));
      state = s;
      key   = k;
      num   = n;
      en    = ($urandom_range(0, 3) != 0);
      if (en && ready) begin
        push(s, k, n);
        acc++;
      end
    end
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    checks++;
    if (acc !== 1000 || sb.size() !== 0) begin
      errors++;
      $display("FAIL random_drain got accepted=%0d pending=%0d want 1000/0",
               acc, sb.size());
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vector();
    test_last_round();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inv_stage3.md
INV_STAGE3 -- requirements
Module: inv_stage3

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  input-valid; when high with ready high, the block accepts state, key and num.
REQ-004 state  input  128  inverse-cipher round state after InvShiftRows/InvSubBytes/AddRoundKey; byte 0 at bits 127:120, column 0 at bits 127:96.
REQ-005 key  input  128  round key passed through unmodified.
REQ-006 num  input  4  round number, 4'h1..4'ha, passed through unmodified.
REQ-007 ready  output  1  high when a new input can be accepted.
REQ-008 done  output  1  one-cycle pulse; state_out, key_out and num_out are valid in that cycle.
REQ-009 state_out  output  128  InvMixColumns(state), or state unchanged for the final round.
REQ-010 key_out  output  128  registered copy of the accepted key.
REQ-011 num_out  output  4  registered copy of the accepted num.

Function
REQ-012 InvMixColumns SHALL multiply each column by the circulant matrix {0e,0b,0d,09} over GF(2^8) with reduction polynomial 0x11b.
REQ-013 When the accepted num == 4'ha, state_out SHALL equal the accepted state bit-for-bit; InvMixColumns is skipped.
REQ-014 The block SHALL accept an input only on a rising edge where en && ready; en with ready low is ignored, with no side effects.
REQ-015 state_out, key_out and num_out SHALL hold their last values until the next result is produced.
REQ-016 done SHALL be high for exactly one cycle per accepted input; results are produced in acceptance order.
REQ-017 Parallel mode (macro undefined): ready SHALL be constant 1; done is asserted in the cycle after acceptance, so latency is 1 and one input per cycle is accepted back-to-back.
REQ-018 Serial mode (macro defined) FSM states SHALL be IDLE, COL and OUT; ready = (FSM == IDLE).
REQ-019 In serial mode, acceptance in IDLE with num != 4'ha SHALL capture the inputs, clear the 2-bit column counter and enter COL.
REQ-020 COL SHALL transform one column per cycle, column 0 (bits 127:96) first, increment the counter, and enter OUT after column 3.
REQ-021 OUT SHALL assert done for one cycle, drive the finished state to state_out and return to IDLE.
REQ-022 In serial mode, num == 4'ha SHALL go IDLE->OUT directly, giving latency 1.
REQ-023 Serial-mode latency for num != 4'ha SHALL be 5 cycles from the accepting edge to the done cycle.
REQ-024 The column counter SHALL wrap 3->0 only on the COL->OUT transition.

Reset
REQ-025 While rst is low, done, state_out, key_out and num_out SHALL be 0, the FSM SHALL be IDLE, the counter 0 and ready 1.
REQ-026 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first cycle after release is IDLE with ready 1.
REQ-027 Reset SHALL take effect without a clock edge, and its release SHALL be sampled synchronously.

Configuration
REQ-028 With INV_STAGE3_SERIAL_EN defined, the block SHALL use the single-column serial datapath and FSM (REQ-018..REQ-024).
REQ-029 Without INV_STAGE3_SERIAL_EN, the block SHALL use a fully parallel 4-column datapath with a 1-cycle pipeline register (REQ-017).
REQ-030 Both builds SHALL produce identical state_out, key_out and num_out for the same accepted inputs.

Verification
REQ-031 state=8e4da1bc_9fdc589d_01010101_c6c6c6c6, num=4'h3, en pulse -> state_out=db135345_f20a225c_01010101_c6c6c6c6; done after 1 cycle (parallel) or 5 cycles (serial).
REQ-032 Same state with num=4'ha -> state_out equals the input state unchanged, num_out=4'ha, done after 1 cycle in both builds.
REQ-033 Parallel build, en high for 4 consecutive cycles with num=1..4 -> 4 consecutive done pulses, num_out=1..4 in order.
REQ-034 Serial build, en held high for 12 cycles -> only 2 inputs accepted, 2 done pulses, ready low while in COL.
REQ-035 Serial build, rst driven low for 1 cycle during COL with counter=2 -> no done pulse, all outputs 0, ready 1 on the next cycle.
REQ-036 Random state/key/num against a software InvMixColumns model, 1000 vectors per build -> zero mismatches; key_out equals key every time.
